// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: a - b - bin, LSB first,
// one full-subtractor cell plus a borrow flop, start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] completed;
  logic             borrow;
  logic             borrow_n;
  logic             x;
  logic             y;
  logic             d;
  logic             load;
  logic             last;

  assign x         = a_sr[0];
  assign y         = b_sr[0];
  assign d         = x ^ y ^ borrow;
  assign borrow_n  = (~x & y) | (~x & borrow) | (y & borrow);
  assign completed = {d, d_sr[WIDTH-1:1]};

  assign load = start && (state != SHIFT);
  assign last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last) state_n = DONE;
      DONE:    state_n = start ? SHIFT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      d_sr   <= completed;
      borrow <= borrow_n;
      cnt    <= cnt + CW'(1);
      // On the MSB step x/y/d are the sign bits of a, b and diff
      if (last) begin
        diff <= completed;
        bout <= borrow_n;
        ovf  <= (x != y) && (d != x);
        zero <= (completed == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with
// hand-computed expected results.
module tb_serial_subtractor;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic       zero;

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Cycles after the current point until done is seen; 99 if never.
  task automatic wait_done(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] ia,
                        input logic [7:0] ib, input logic ibin,
                        input logic [7:0] ed, input logic eb,
                        input logic eo, input logic ez);
    int n;
    a = ia;
    b = ib;
    bin = ibin;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_done(n);
    check({tag, "_lat"}, n, 8);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_zero"}, zero, ez);
    step();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_diff_hold"}, diff, ed);
  endtask

  initial begin
    int n;
    int bad;
    int seen;
    int last_t;
    int gap_bad;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 0);
    step();
    step();
    reset = 1'b0;
    step();

    run_op("sub35_12", 8'h35, 8'h12, 0, 8'h23, 0, 0, 0);
    run_op("sub12_35", 8'h12, 8'h35, 0, 8'hDD, 1, 0, 0);
    run_op("sub80_01", 8'h80, 8'h01, 0, 8'h7F, 0, 1, 0);
    // 127 - (-1) = 128 does not fit in 8 signed bits
    run_op("sub7f_ff", 8'h7F, 8'hFF, 0, 8'h80, 1, 1, 0);
    run_op("sub40_3f_b", 8'h40, 8'h3F, 1, 8'h00, 0, 0, 1);
    run_op("sub00_00_b", 8'h00, 8'h00, 1, 8'hFF, 1, 0, 0);

    // start during SHIFT is ignored
    a = 8'h35;
    b = 8'h12;
    bin = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(n);
    check("ign_lat", n + 3, 8);
    check("ign_diff", diff, 8'h23);
    check("ign_bout", bout, 0);
    step();
    check("ign_idle", busy, 0);

    // asynchronous reset mid-operation
    a = 8'h12;
    b = 8'h35;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    step();
    #1;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_diff", diff, 0);
    check("arst_bout", bout, 0);
    check("arst_ovf", ovf, 0);
    check("arst_zero", zero, 0);
    step();
    reset = 1'b0;
    step();
    run_op("post_rst", 8'h35, 8'h12, 0, 8'h23, 0, 0, 0);

    // start held high: one result every 9 cycles
    a = 8'h05;
    b = 8'h03;
    bin = 1'b0;
    start = 1'b1;
    step();
    bad = 0;
    seen = 0;
    last_t = 0;
    gap_bad = 0;
    for (int t = 1; t <= 27; t++) begin
      step();
      if ((busy ^ done) !== 1'b1) bad++;
      if (done) begin
        if (diff !== 8'h02) bad++;
        if (seen == 0 && t != 8) gap_bad++;
        if (seen > 0 && t - last_t != 9) gap_bad++;
        seen++;
        last_t = t;
      end
    end
    start = 1'b0;
    check("hold_count", seen, 3);
    check("hold_period", gap_bad, 0);
    check("hold_busy_done", bad, 0);
    check("hold_diff", diff, 8'h02);
    wait_done(n);
    check("hold_tail_lat", n, 9 - 1);
    step();
    check("hold_end_idle", busy | done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
